// File: rtl/iq_sample_packer_if.sv
// Avalon-ST source port carrying packed 32-bit IQ words toward the downstream FIFO.
interface iq_sample_packer_if;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/iq_sample_packer.sv
// Packs pairs of 16-bit ADC samples into 32-bit words and buffers them for an Avalon-ST sink.
// Optional feature macro: IQ_PACK_OVF_CNT_EN adds the ovf_count port and its saturating counter.
module iq_sample_packer #(
    parameter int CAPTURE_WORDS = 1024,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic               sys_clk_clk,
    input  logic               reset_reset_n,
    input  logic               capture_start,
    input  logic               adc_valid,
    input  logic [15:0]        adc_sample,
    iq_sample_packer_if.master st_out,
    output logic               busy,
    output logic               done,
    output logic               overflow
`ifdef IQ_PACK_OVF_CNT_EN
    ,
    output logic [15:0]        ovf_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [16:0]      WORDS_TGT = 17'(CAPTURE_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_cs_d;
    logic              r_phase;
    logic [15:0]       r_lo;
    logic [31:0]       r_word;
    logic              r_push_pend;
    logic [15:0]       r_wcnt;
    logic              r_overflow;
    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_cs_rise;
    logic w_enter_cap;
    logic w_in_capture;
    logic w_valid;
    logic w_pop;
    logic w_full;
    logic w_push_ok;
    logic w_drop;
    logic w_last_push;
    logic w_busy_nxt;
    logic w_done_nxt;

    assign w_cs_rise    = capture_start & ~r_cs_d;
    assign w_enter_cap  = (r_state == S_IDLE) & w_cs_rise;
    assign w_in_capture = (r_state == S_CAPTURE);
    assign w_valid      = (r_count != {CNT_W{1'b0}});
    assign w_pop        = w_valid & st_out.out_ready;
    assign w_full       = (r_count == CNT_FULL);
    // A full FIFO still takes the word when the head leaves on the same edge.
    assign w_push_ok    = w_in_capture & r_push_pend & (~w_full | w_pop);
    assign w_drop       = w_in_capture & r_push_pend & w_full & ~w_pop;
    assign w_last_push  = w_push_ok & (({1'b0, r_wcnt} + 17'd1) == WORDS_TGT);

    assign st_out.out_valid = w_valid;
    assign st_out.out_data  = w_valid ? r_mem[r_rd_ptr] : 32'h0000_0000;
    assign busy             = r_busy;
    assign done             = r_done;
    assign overflow         = r_overflow;

    // State register and capture_start edge-detect flop.
    always_ff @(posedge sys_clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
            r_cs_d  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_cs_d  <= capture_start;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cs_rise) w_next_state = S_CAPTURE;
                else           w_next_state = S_IDLE;
            end
            S_CAPTURE: begin
                if (w_last_push) w_next_state = S_DRAIN;
                else             w_next_state = S_CAPTURE;
            end
            S_DRAIN: begin
                if (!w_valid) w_next_state = S_DONE;
                else          w_next_state = S_DRAIN;
            end
            S_DONE: begin
                if (!capture_start) w_next_state = S_IDLE;
                else                w_next_state = S_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Status decode from the upcoming state so busy/done come straight from flops.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_next_state)
            S_CAPTURE: w_busy_nxt = 1'b1;
            S_DRAIN:   w_busy_nxt = 1'b1;
            S_DONE:    w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge sys_clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Sample pairing: low half first, completed word pushed on the following cycle.
    always_ff @(posedge sys_clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_phase     <= 1'b0;
            r_lo        <= 16'h0000;
            r_word      <= 32'h0000_0000;
            r_push_pend <= 1'b0;
        end else if (w_enter_cap) begin
            r_phase     <= 1'b0;
            r_push_pend <= 1'b0;
        end else if (w_in_capture && adc_valid) begin
            if (!r_phase) begin
                r_lo        <= adc_sample;
                r_phase     <= 1'b1;
                r_push_pend <= 1'b0;
            end else begin
                r_word      <= {adc_sample, r_lo};
                r_phase     <= 1'b0;
                r_push_pend <= 1'b1;
            end
        end else begin
            r_push_pend <= 1'b0;
        end
    end

    // Accepted-word counter and sticky overflow flag.
    always_ff @(posedge sys_clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wcnt     <= 16'h0000;
            r_overflow <= 1'b0;
        end else if (w_enter_cap) begin
            r_wcnt     <= 16'h0000;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wcnt <= r_wcnt + 16'd1;
            if (w_drop)    r_overflow <= 1'b1;
        end
    end

`ifdef IQ_PACK_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;
    assign ovf_count = r_ovf_cnt;

    // Saturating dropped-word counter.
    always_ff @(posedge sys_clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ovf_cnt <= 16'h0000;
        end else if (w_enter_cap) begin
            r_ovf_cnt <= 16'h0000;
        end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end else begin
            r_ovf_cnt <= r_ovf_cnt;
        end
    end
`endif

    // FIFO storage; contents need no reset because out_data is gated by valid.
    always_ff @(posedge sys_clk_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= r_word;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge sys_clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_sample_packer.sv
// Randomized scoreboard bench for iq_sample_packer: expected words queued at stimulus, popped by a monitor.
`timescale 1ns/1ps
module tb_iq_sample_packer;

    localparam int CW    = 1024;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_sample = 16'h0000;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef IQ_PACK_OVF_CNT_EN
    logic [15:0] ovf_count;
`endif

    iq_sample_packer_if st_if ();

    iq_sample_packer #(.CAPTURE_WORDS(CW), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk_clk   (clk),
        .reset_reset_n (rst_n),
        .capture_start (cs),
        .adc_valid     (adc_valid),
        .adc_sample    (adc_sample),
        .st_out        (st_if),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow)
`ifdef IQ_PACK_OVF_CNT_EN
        ,
        .ovf_count     (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    int          sent_words = 0;
    int          popped_words = 0;
    int          ready_mode = 0;
    logic        held = 1'b0;
    logic [31:0] held_data = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word from two samples; flow control keeps the buffer from filling in no-drop phases.
    task automatic send_word(input logic [15:0] lo, input logic [15:0] hi, input bit keep, input bit flow);
        int guard;
        adc_valid = 1'b1;
        adc_sample = lo;
        tick();
        adc_valid = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
        guard = 0;
        while (flow && (sent_words - popped_words >= DEPTH - 1) && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL flow_wait: in-flight %0d expected below %0d", sent_words - popped_words, DEPTH - 1);
        end
        adc_valid = 1'b1;
        adc_sample = hi;
        tick();
        adc_valid = 1'b0;
        if (keep) begin
            exp_q.push_back({hi, lo});
            sent_words++;
        end
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 20000) begin
            tick();
            n++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // Ready driver.
    initial begin
        st_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       st_if.out_ready = 1'b0;
                1:       st_if.out_ready = 1'b1;
                default: st_if.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: hold-stability and in-order delivery against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", 32'(st_if.out_valid), 32'd1);
                    chk("hold_data", st_if.out_data, held_data);
                end
                if (st_if.out_valid && st_if.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL extra_word: got %h expected no word", st_if.out_data);
                    end else begin
                        chk("word", st_if.out_data, exp_q.pop_front());
                    end
                    popped_words++;
                end
                held = st_if.out_valid && !st_if.out_ready;
                held_data = st_if.out_data;
            end
        end
    end

    initial begin
        // Reset with capture_start already high: release must not start a capture.
        repeat (3) tick();
        chk("rst_valid", 32'(st_if.out_valid), 32'd0);
        chk("rst_data", st_if.out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef IQ_PACK_OVF_CNT_EN
        chk("rst_ovf_count", 32'(ovf_count), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (3) tick();
        chk("no_start_at_release", 32'(busy), 32'd0);
        cs = 1'b0;
        tick();

        // Capture 1: directed first words, then random data with random ready.
        ready_mode = 2;
        sent_words = 0;
        popped_words = 0;
        cs = 1'b1;
        tick();
        cs = 1'b0;
        chk("cap1_busy", 32'(busy), 32'd1);
        adc_valid = 1'b1;
        adc_sample = 16'h0001;
        tick();
        adc_sample = 16'h0002;
        tick();
        adc_valid = 1'b0;
        exp_q.push_back(32'h0002_0001);
        sent_words++;
        chk("lat_n1_valid", 32'(st_if.out_valid), 32'd0);
        tick();
        chk("lat_n2_valid", 32'(st_if.out_valid), 32'd1);
        chk("lat_n2_data", st_if.out_data, 32'h0002_0001);
        send_word(16'h0003, 16'h0004, 1'b1, 1'b1);
        send_word(16'h0005, 16'h0006, 1'b1, 1'b1);
        send_word(16'h0007, 16'h0008, 1'b1, 1'b1);
        for (int i = 4; i < CW; i++) begin
            send_word(16'($urandom), 16'($urandom), 1'b1, 1'b1);
        end
        // Extra samples after the last word must be ignored.
        adc_valid = 1'b1;
        adc_sample = 16'hDEAD;
        tick();
        adc_sample = 16'hBEEF;
        tick();
        adc_valid = 1'b0;
        wait_done("cap1_done");
        chk("cap1_ovf", 32'(overflow), 32'd0);
        chk("cap1_words", 32'(popped_words), 32'(CW));
        chk("cap1_q_empty", 32'(exp_q.size()), 32'd0);
        chk("cap1_busy_end", 32'(busy), 32'd0);
        cs = 1'b0;
        repeat (2) tick();
        chk("cap1_idle", 32'(done), 32'd0);

        // Capture 2: ready held low, 6 words into a 4-deep buffer, start held high throughout.
        ready_mode = 0;
        sent_words = 0;
        popped_words = 0;
        cs = 1'b1;
        tick();
        chk("cap2_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            send_word(16'($urandom), 16'($urandom), (i < DEPTH), 1'b0);
        end
        repeat (3) tick();
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_valid", 32'(st_if.out_valid), 32'd1);
        chk("ovf_head", st_if.out_data, exp_q[0]);
`ifdef IQ_PACK_OVF_CNT_EN
        chk("ovf_count", 32'(ovf_count), 32'd2);
`endif
        repeat (5) tick();
        ready_mode = 1;
        for (int i = DEPTH; i < CW; i++) begin
            send_word(16'($urandom), 16'($urandom), 1'b1, 1'b1);
        end
        wait_done("cap2_done");
        chk("cap2_ovf_sticky", 32'(overflow), 32'd1);
        chk("cap2_words", 32'(popped_words), 32'(CW));
        chk("cap2_q_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("done_hold", 32'(done), 32'd1);
        end
        cs = 1'b0;
        repeat (2) tick();
        chk("done_drop", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        cs = 1'b1;
        tick();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_ovf_clr", 32'(overflow), 32'd0);
`ifdef IQ_PACK_OVF_CNT_EN
        chk("restart_cnt_clr", 32'(ovf_count), 32'd0);
`endif

        // Capture 3: reset after three samples discards the buffered word.
        ready_mode = 0;
        adc_valid = 1'b1;
        adc_sample = 16'h1111;
        tick();
        adc_sample = 16'h2222;
        tick();
        adc_sample = 16'h3333;
        tick();
        adc_valid = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(st_if.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(st_if.out_valid), 32'd0);
        chk("mid_rst_data", st_if.out_data, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        ready_mode = 1;
        for (int i = 0; i < 12; i++) begin
            adc_valid = 1'($urandom_range(0, 1));
            adc_sample = 16'($urandom);
            tick();
            chk("post_rst_valid", 32'(st_if.out_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        adc_valid = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
